// File: rtl/bitcell_bank_pkg.sv
// Shared constants for the two-requester bitcell bank arbiter.
// Holds the state encoding and the default bank geometry.
package bitcell_bank_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_ACCESS = ACCESS,
        ST_DONE   = DONE
    } state_t;

endpackage

// File: rtl/bitcell_word.sv
// One bank word: a WIDTH-bit register with write enable.
// The asynchronous clear lets a bank reset land mid-access.
module bitcell_word
    import bitcell_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bitcell_bank_arbiter.sv
// Round-robin access controller sharing a small register bank between two
// requesters: IDLE selects a winner, ACCESS performs it, DONE acks it.
module bitcell_bank_arbiter
    import bitcell_bank_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [WIDTH-1:0]  rdata,
    output logic              busy
);

    state_t             state_q;
    state_t             state_d;
    logic               take;
    logic               pick;
    logic               sel_q;
    logic               last_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [WIDTH-1:0]   rdata_q;
    logic [DEPTH-1:0]   word_we;
    logic [WIDTH-1:0]   word_q [DEPTH];

    // On a tie the requester that was not served last wins; otherwise whoever asks.
    always_comb begin
        pick    = (req0 && req1) ? ~last_q : req1;
        take    = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    take    = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                sel_q  <= pick;
                last_q <= pick;
            end
            if (state_q == ST_ACCESS) begin
                rdata_q <= we_q ? '0 : word_q[addr_q];
            end else if (state_q == ST_DONE) begin
                rdata_q <= '0;
            end
        end
    end

    // Operands are captured once at selection so the requester may change them afterwards.
    always_ff @(posedge clk) begin
        if (take) begin
            we_q    <= pick ? we1    : we0;
            addr_q  <= pick ? addr1  : addr0;
            wdata_q <= pick ? wdata1 : wdata0;
        end
    end

    always_comb begin
        word_we = '0;
        if (state_q == ST_ACCESS && we_q) begin
            word_we[addr_q] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        bitcell_word #(
            .WIDTH(WIDTH)
        ) u_word (
            .clk  (clk),
            .rst_n(rst_n),
            .we   (word_we[i]),
            .d    (wdata_q),
            .q    (word_q[i])
        );
    end

    assign gnt0  = (state_q == ST_ACCESS) && !sel_q;
    assign gnt1  = (state_q == ST_ACCESS) &&  sel_q;
    assign ack0  = (state_q == ST_DONE)   && !sel_q;
    assign ack1  = (state_q == ST_DONE)   &&  sel_q;
    assign busy  = (state_q != ST_IDLE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_bitcell_bank_arbiter.sv
// Directed bench for bitcell_bank_arbiter: a transaction-level model of the
// bank is checked against the DUT every cycle, plus literal expectations.
module tb_bitcell_bank_arbiter;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [WIDTH-1:0]  wdata0 = '0, wdata1 = '0;
    logic              gnt0, gnt1, ack0, ack1, busy;
    logic [WIDTH-1:0]  rdata;

    int n_vec = 0;
    int n_err = 0;

    bitcell_bank_arbiter #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .we0   (we0),
        .addr0 (addr0),
        .wdata0(wdata0),
        .req1  (req1),
        .we1   (we1),
        .addr1 (addr1),
        .wdata1(wdata1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .ack0  (ack0),
        .ack1  (ack1),
        .rdata (rdata),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    // m_phase: 0 = free, 1 = access in its grant cycle, 2 = access in its ack cycle
    int          m_phase;
    logic        m_who, m_last, m_we;
    logic [1:0]  m_addr;
    logic [7:0]  m_wd, m_rd;
    logic [7:0]  m_mem [DEPTH];

    function automatic logic winner(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return (last == 1'b0) ? 1'b1 : 1'b0;
        return r0 ? 1'b0 : 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_last  <= 1'b1;
            m_who   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wd    <= '0;
            m_rd    <= '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
        end else if (m_phase == 0) begin
            if (req0 || req1) begin
                m_who   <= winner(req0, req1, m_last);
                m_last  <= winner(req0, req1, m_last);
                m_we    <= winner(req0, req1, m_last) ? we1 : we0;
                m_addr  <= winner(req0, req1, m_last) ? addr1 : addr0;
                m_wd    <= winner(req0, req1, m_last) ? wdata1 : wdata0;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (m_we) m_mem[m_addr] <= m_wd;
            m_rd    <= m_we ? 8'h00 : m_mem[m_addr];
            m_phase <= 2;
        end else begin
            m_phase <= 0;
        end
    end

    logic [12:0] dut_vec, exp_vec;
    assign dut_vec = {gnt0, gnt1, ack0, ack1, busy, rdata};
    assign exp_vec = {(m_phase == 1) && !m_who, (m_phase == 1) && m_who,
                      (m_phase == 2) && !m_who, (m_phase == 2) && m_who,
                      (m_phase != 0), (m_phase == 2) ? m_rd : 8'h00};

    always @(negedge clk) begin
        check("cycle_outputs", 32'(dut_vec), 32'(exp_vec));
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_r0(input logic r, input logic w, input logic [1:0] a, input logic [7:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic set_r1(input logic r, input logic w, input logic [1:0] a, input logic [7:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    // which: 0 gnt0, 1 gnt1, 2 ack0, 3 ack1
    task automatic wait_sig(input int which, input string name, output int cyc);
        bit seen;
        logic s;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            case (which)
                0:       s = gnt0;
                1:       s = gnt1;
                2:       s = ack0;
                default: s = ack1;
            endcase
            if (s) begin
                seen = 1'b1;
                cyc  = i;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic access(input int who, input logic w, input logic [1:0] a, input logic [7:0] d,
                          input string name, output logic [7:0] rd, output int lat);
        @(negedge clk);
        if (who == 0) set_r0(1'b1, w, a, d);
        else          set_r1(1'b1, w, a, d);
        wait_sig(2 + who, name, lat);
        rd = rdata;
        if (who == 0) set_r0(1'b0, 1'b0, 2'd0, 8'h00);
        else          set_r1(1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic do_reset();
        set_r0(1'b0, 1'b0, 2'd0, 8'h00);
        set_r1(1'b0, 1'b0, 2'd0, 8'h00);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rd;
        logic [3:0] ord;
        int         lat;
        int         n;

        // Reset then idle
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(dut_vec), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_outputs", 32'(dut_vec), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            access(0, 1'b0, 2'(a), 8'h00, "init_read_ack", rd, lat);
            check("init_word_zero", 32'(rd), 32'd0);
        end

        // Single write then read
        access(0, 1'b1, 2'd2, 8'hA5, "wr_a5_ack", rd, lat);
        check("wr_latency", 32'(lat), 32'd2);
        check("wr_rdata_zero", 32'(rd), 32'd0);
        access(0, 1'b0, 2'd2, 8'h00, "rd_a5_ack", rd, lat);
        check("rd_a5_value", 32'(rd), 32'hA5);
        check("rd_latency", 32'(lat), 32'd2);

        // Tie-break and fairness from reset
        do_reset();
        @(negedge clk);
        set_r0(1'b1, 1'b1, 2'd0, 8'h11);
        set_r1(1'b1, 1'b1, 2'd1, 8'h22);
        ord = '0;
        n   = 0;
        for (int i = 0; i < 30 && n < 4; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                ord[n] = gnt1;
                n++;
            end
        end
        set_r0(1'b0, 1'b0, 2'd0, 8'h00);
        set_r1(1'b0, 1'b0, 2'd0, 8'h00);
        check("tie_grant_count", 32'(n), 32'd4);
        check("tie_grant_order", 32'(ord), 32'b1010);
        repeat (3) @(negedge clk);
        access(0, 1'b0, 2'd0, 8'h00, "tie_rd0_ack", rd, lat);
        check("tie_word0", 32'(rd), 32'h11);
        access(1, 1'b0, 2'd1, 8'h00, "tie_rd1_ack", rd, lat);
        check("tie_word1", 32'(rd), 32'h22);

        // Cross-requester coherence: req0 reads while req1's write is in flight
        @(negedge clk);
        set_r1(1'b1, 1'b1, 2'd3, 8'h3C);
        wait_sig(1, "coh_gnt1_seen", lat);
        set_r0(1'b1, 1'b0, 2'd3, 8'h00);
        wait_sig(3, "coh_ack1_seen", lat);
        set_r1(1'b0, 1'b0, 2'd0, 8'h00);
        wait_sig(0, "coh_gnt0_seen", lat);
        check("coh_gnt0_delay", 32'(lat), 32'd2);
        wait_sig(2, "coh_ack0_seen", lat);
        check("coh_rdata", 32'(rdata), 32'h3C);
        set_r0(1'b0, 1'b0, 2'd0, 8'h00);

        // Operand change after grant is ignored
        @(negedge clk);
        set_r0(1'b1, 1'b1, 2'd1, 8'hF0);
        wait_sig(0, "opchg_gnt0_seen", lat);
        wdata0 = 8'h0F;
        wait_sig(2, "opchg_ack0_seen", lat);
        set_r0(1'b0, 1'b0, 2'd0, 8'h00);
        access(0, 1'b0, 2'd1, 8'h00, "opchg_rd_ack", rd, lat);
        check("opchg_word1", 32'(rd), 32'hF0);

        // Reset in the middle of a write
        @(negedge clk);
        set_r0(1'b1, 1'b1, 2'd0, 8'hFF);
        wait_sig(0, "mid_gnt0_seen", lat);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", 32'(dut_vec), 32'd0);
        set_r0(1'b0, 1'b0, 2'd0, 8'h00);
        repeat (2) @(negedge clk);
        check("mid_reset_held", 32'(dut_vec), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_idle", 32'(dut_vec), 32'd0);
        access(0, 1'b0, 2'd0, 8'h00, "mid_rd0_ack", rd, lat);
        check("mid_word0_zero", 32'(rd), 32'd0);
        access(1, 1'b0, 2'd3, 8'h00, "mid_rd3_ack", rd, lat);
        check("mid_word3_zero", 32'(rd), 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
